// File: rtl/mio_pkg.sv
// Shared constants and address decode for the MIO bus controller.
package mio_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] LED_BASE     = 32'hE000_0000;
  localparam logic [31:0] SW_BASE      = 32'hF000_0000;
  localparam logic [31:0] TCOUNT_BASE  = 32'hF000_0004;
  localparam logic [31:0] TCMP_BASE    = 32'hF000_0008;
  localparam logic [31:0] TCTRL_BASE   = 32'hF000_000C;
  localparam logic [31:0] RAM_WIN_MASK = 32'hFFFF_F000;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO_CLR = 1;
  localparam int CTRL_FLAG     = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL
  } sel_e;

  // Byte offset within the word is ignored; only word addresses decode.
  function automatic sel_e decode(input logic [31:0] addr);
    logic [31:0] w;
    sel_e        s;
    w = addr & ~32'h3;
    s = SEL_NONE;
    if ((w & RAM_WIN_MASK) == RAM_BASE) s = SEL_RAM;
    else if (w == LED_BASE)             s = SEL_LED;
    else if (w == SW_BASE)              s = SEL_SW;
    else if (w == TCOUNT_BASE)          s = SEL_TCOUNT;
    else if (w == TCMP_BASE)            s = SEL_TCMP;
    else if (w == TCTRL_BASE)           s = SEL_TCTRL;
    return s;
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side memory/IO bus: store strobe, address, store data and load data.
interface mio_bus_ctrl_if;
  logic        cpu_memw;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;

  modport master (output cpu_memw, cpu_addr, cpu_wdata, input cpu_rdata);
  modport slave  (input cpu_memw, cpu_addr, cpu_wdata, output cpu_rdata);
endinterface

// File: rtl/mio_timer.sv
// 32-bit free-running timer with compare match, auto-clear and W1C flag.
module mio_timer
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  sel_e        sel,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count_q;
  logic [31:0] cmp_q;
  logic        en_q;
  logic        ac_q;
  logic        flag_q;

  logic wr_count, wr_cmp, wr_ctrl, match, run;

  assign wr_count = we && (sel == SEL_TCOUNT);
  assign wr_cmp   = we && (sel == SEL_TCMP);
  assign wr_ctrl  = we && (sel == SEL_TCTRL);
  assign match    = en_q && (count_q == cmp_q);
  // A CTRL write dropping EN suppresses the increment on that same edge.
  assign run      = en_q && !(wr_ctrl && !wdata[CTRL_EN]);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      ac_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      if (wr_count)
        count_q <= wdata;
      else if (run)
        count_q <= (match && ac_q) ? '0 : count_q + 32'd1;
      if (wr_cmp)
        cmp_q <= wdata;
      if (wr_ctrl) begin
        en_q <= wdata[CTRL_EN];
        ac_q <= wdata[CTRL_AUTO_CLR];
      end
      if (match)
        flag_q <= 1'b1;
      else if (wr_ctrl && wdata[CTRL_FLAG])
        flag_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_TCOUNT: rdata = count_q;
      SEL_TCMP:   rdata = cmp_q;
      SEL_TCTRL: begin
        rdata[CTRL_EN]       = en_q;
        rdata[CTRL_AUTO_CLR] = ac_q;
        rdata[CTRL_FLAG]     = flag_q;
      end
      default: ;
    endcase
  end

  assign irq = flag_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: data RAM, LED register, switch synchroniser, timer.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_WORDS   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mio_bus_ctrl_if.slave  bus,
  input  logic [15:0]    sw_in,
  output logic [15:0]    led_out,
  output logic           timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [RAM_WORDS];
  logic [15:0]   led_q;
  logic [15:0]   sync_q [SYNC_STAGES];
  logic [31:0]   timer_rdata;

  assign sel     = decode(bus.cpu_addr);
  assign ram_idx = bus.cpu_addr[2 +: AW];

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.cpu_memw && (sel == SEL_RAM))
      ram[ram_idx] <= bus.cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      led_q <= '0;
    else if (bus.cpu_memw && (sel == SEL_LED))
      led_q <= bus.cpu_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  mio_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (bus.cpu_memw),
    .wdata (bus.cpu_wdata),
    .rdata (timer_rdata),
    .irq   (timer_irq)
  );

  always_comb begin
    bus.cpu_rdata = '0;
    case (sel)
      SEL_RAM:                          bus.cpu_rdata = ram[ram_idx];
      SEL_LED:                          bus.cpu_rdata = {16'h0, led_q};
      SEL_SW:                           bus.cpu_rdata = {16'h0, sync_q[SYNC_STAGES-1]};
      SEL_TCOUNT, SEL_TCMP, SEL_TCTRL:  bus.cpu_rdata = timer_rdata;
      default: ;
    endcase
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl with a register-level reference model.
module tb_mio_bus_ctrl;

  localparam int RAM_WORDS   = 1024;
  localparam int SYNC_STAGES = 2;

  localparam logic [31:0] A_LED = 32'hE000_0000;
  localparam logic [31:0] A_SW  = 32'hF000_0000;
  localparam logic [31:0] A_CNT = 32'hF000_0004;
  localparam logic [31:0] A_CMP = 32'hF000_0008;
  localparam logic [31:0] A_CTL = 32'hF000_000C;
  localparam logic [31:0] A_UNM = 32'hD000_0000;

  logic        clk;
  logic        reset;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        timer_irq;

  mio_bus_ctrl_if bus ();

  mio_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else
      passed++;
  endfunction

  // Reference model: architectural register values only.
  bit          mv = 0;
  logic [31:0] m_ram [int];
  logic [15:0] m_led;
  logic [31:0] m_count, m_cmp;
  bit          m_en, m_ac, m_flag;
  logic [15:0] m_swq [$];

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] w;
    int          idx;
    w = a & ~32'h3;
    v = 32'h0;
    if (w < 32'h1000) begin
      idx = int'(w[31:2]) % RAM_WORDS;
      if (!m_ram.exists(idx)) return 0;
      v = m_ram[idx];
    end
    else if (w == A_LED) v = {16'h0, m_led};
    else if (w == A_SW)  v = (m_swq.size() >= SYNC_STAGES) ? {16'h0, m_swq[SYNC_STAGES-1]} : 32'h0;
    else if (w == A_CNT) v = m_count;
    else if (w == A_CMP) v = m_cmp;
    else if (w == A_CTL) v = {29'h0, m_flag, m_ac, m_en};
    return 1;
  endfunction

  logic [31:0] t_w, n_count;
  bit          t_wr, t_hit, n_flag;

  always @(posedge clk) begin
    t_w  = bus.cpu_addr & ~32'h3;
    t_wr = bus.cpu_memw;
    if (t_wr && t_w < 32'h1000) m_ram[int'(t_w[31:2]) % RAM_WORDS] = bus.cpu_wdata;
    if (reset) begin
      mv = 1; m_led = 16'h0; m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
      m_en = 0; m_ac = 0; m_flag = 0; m_swq.delete();
    end else begin
      t_hit   = m_en && (m_count == m_cmp);
      n_count = m_count;
      if (m_en && !(t_wr && t_w == A_CTL && !bus.cpu_wdata[0]))
        n_count = (t_hit && m_ac) ? 32'h0 : m_count + 1;
      if (t_wr && t_w == A_CNT) n_count = bus.cpu_wdata;
      n_flag = m_flag;
      if (t_wr && t_w == A_CTL && bus.cpu_wdata[2]) n_flag = 0;
      if (t_hit) n_flag = 1;
      if (t_wr && t_w == A_CTL) begin m_en = bus.cpu_wdata[0]; m_ac = bus.cpu_wdata[1]; end
      if (t_wr && t_w == A_CMP) m_cmp = bus.cpu_wdata;
      if (t_wr && t_w == A_LED) m_led = bus.cpu_wdata[15:0];
      m_count = n_count;
      m_flag  = n_flag;
      m_swq.push_front(sw_in);
      if (m_swq.size() > SYNC_STAGES) void'(m_swq.pop_back());
    end
  end

  logic [31:0] c_v;
  always @(negedge clk) begin
    if (mv) begin
      if (m_read(bus.cpu_addr, c_v)) chk("model_rdata", bus.cpu_rdata, c_v);
      chk("model_led", {16'h0, led_out}, {16'h0, m_led});
      chk("model_irq", {31'h0, timer_irq}, {31'h0, m_flag});
    end
  end

  task automatic drive(input bit m, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    bus.cpu_memw  = m;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk(name, bus.cpu_rdata, exp);
  endtask

  logic [31:0] exp_auto  [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
  bit          irq_auto  [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    reset = 1'b1; sw_in = 16'h0;
    bus.cpu_memw = 1'b0; bus.cpu_addr = A_UNM; bus.cpu_wdata = 32'h0;
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;

    drive(0, A_CMP, 0); lit("rst_compare", 32'hFFFF_FFFF);
    drive(0, A_CTL, 0); lit("rst_ctrl", 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    drive(0, A_CNT, 0); lit("rst_count", 32'h0);

    drive(1, 32'hC, 32'hCAFE_F00D);
    drive(1, 32'h8, 32'h0);
    drive(1, 32'h8, 32'h1234_5678);
    drive(0, 32'h8, 0); lit("ram_8", 32'h1234_5678);
    drive(0, 32'h9, 0); lit("ram_9", 32'h1234_5678);
    drive(0, 32'hC, 0); lit("ram_c", 32'hCAFE_F00D);
    drive(1, 32'h8, 32'hDEAD_BEEF); lit("ram_same_cycle_old", 32'h1234_5678);
    drive(0, 32'h8, 0); lit("ram_8_new", 32'hDEAD_BEEF);

    drive(1, A_LED, 32'hABCD_1234);
    drive(0, A_LED, 0); lit("led_read", 32'h0000_1234);
    chk("led_out", {16'h0, led_out}, 32'h0000_1234);
    drive(1, A_UNM, 32'hFFFF_FFFF); lit("unmapped_same", 32'h0);
    drive(0, A_UNM, 0); lit("unmapped_read", 32'h0);
    chk("led_after_unmapped", {16'h0, led_out}, 32'h0000_1234);
    drive(0, A_LED, 0); lit("led_read_again", 32'h0000_1234);

    @(posedge clk); #2;
    sw_in = 16'h00F0; bus.cpu_memw = 0; bus.cpu_addr = A_SW;
    lit("sw_edge0", 32'h0);
    lit("sw_edge1", 32'h0);
    lit("sw_edge2", 32'h0000_00F0);
    drive(1, A_SW, 32'h0); lit("sw_write_ignored", 32'h0000_00F0);

    drive(1, A_CMP, 32'd3);
    drive(1, A_CTL, 32'h3);
    for (int i = 0; i < 6; i++) begin
      drive(0, A_CNT, 0);
      lit($sformatf("auto_count_%0d", i), exp_auto[i]);
      chk($sformatf("auto_irq_%0d", i), {31'h0, timer_irq}, {31'h0, irq_auto[i]});
    end
    drive(1, A_CTL, 32'h4);
    drive(0, A_CTL, 0); lit("ctrl_after_w1c", 32'h0);
    chk("irq_after_w1c", {31'h0, timer_irq}, 32'h0);

    drive(1, A_CNT, 32'd0);
    drive(1, A_CMP, 32'd5);
    drive(1, A_CTL, 32'h1);
    for (int i = 0; i < 7; i++) begin
      drive(0, A_CNT, 0);
      lit($sformatf("run_count_%0d", i), 32'(i));
    end
    chk("run_irq_after_5", {31'h0, timer_irq}, 32'h1);
    drive(1, A_CNT, 32'd2); lit("count_write_old", 32'd7);
    drive(0, A_CNT, 0);     lit("count_override", 32'd2);
    drive(0, A_CNT, 0);     lit("count_resume", 32'd3);

    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    lit("midrst_count", 32'h0);
    chk("midrst_led", {16'h0, led_out}, 32'h0);
    chk("midrst_irq", {31'h0, timer_irq}, 32'h0);
    drive(0, A_CMP, 0); lit("midrst_compare", 32'hFFFF_FFFF);
    drive(0, A_CTL, 0); lit("midrst_ctrl", 32'h0);
    drive(0, A_CNT, 0); lit("midrst_stopped", 32'h0);
    drive(0, A_SW, 0);  lit("midrst_sw", 32'h0000_00F0);

    repeat (3) drive(0, A_UNM, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
